mips_cpu: RTL and testbench
===========================

Name: mips_cpu

Overview:
- Single-cycle MIPS-32 subset core with CP0, precise exceptions and one external interrupt line.
- Instruction and data memories are external, with combinational read and write on posedge.
- A built-in bridge routes stores either to data memory or to the interrupt-generator acknowledge port (0x7F20).
- Trace outputs (PC, register writes, store addresses) feed the system bench and logger.

Parameters:
- PC_RESET, 32'h0000_3000, first fetch address.
- HANDLER_PC, 32'h0000_4180, exception/interrupt entry.
- DM_LIMIT, 32'h0000_3000, data memory occupies [0, DM_LIMIT).

Ports:
- clk  in  1  clock, rising edge active.
- reset  in  1  synchronous, active-high.
- interrupt  in  1  external interrupt request (HWInt[2]); level, held until acknowledged.
- macroscopic_pc  out  32  PC of the instruction committing this cycle.
- i_inst_addr  out  32  fetch address (= PC).
- i_inst_rdata  in  32  instruction word, combinational.
- m_data_addr  out  32  load/store byte address.
- m_data_rdata  in  32  word at m_data_addr>>2, combinational.
- m_data_wdata  out  32  store data, lane-aligned.
- m_data_byteen  out  4  DM byte write enables.
- m_int_addr  out  32  interrupt-generator address (= m_data_addr).
- m_int_byteen  out  4  interrupt-generator byte enables.
- m_inst_addr  out  32  PC of the instruction doing memory access (= PC).
- w_grf_we  out  1  register-file write enable.
- w_grf_addr  out  5  destination register.
- w_grf_wdata  out  32  write-back data.
- w_inst_addr  out  32  PC of the writing instruction (= PC).

Behaviour:
- Reset (synchronous, active-high): PC=PC_RESET; all 32 GPRs=0; SR, Cause, EPC=0. While reset is high, byteen outputs=0 and w_grf_we=0.
- One instruction commits per cycle. There are no delay slots: a taken branch/jump goes directly to its target, and Cause.BD is always 0.
- ISA: add, addu, sub, subu, and, or, slt, sltu, sll, addi, addiu, andi, ori, lui, lw, lh, lhu, lb, lbu, sw, sh, sb, beq, bne, j, jal, jr, mfc0, mtc0, eret, syscall. nop = sll $0.
  - add, addi and sub trap on signed overflow; the addu/addiu/subu forms do not.
  - andi/ori zero-extend the immediate; other immediates sign-extend.
  - jal writes PC+4 to $31.
- $0 always reads 0. w_grf_we=1 for any $0-target write, but the write itself is ignored.
- Stores:
  - sw: byteen=4'b1111.
  - sh: byteen 4'b0011 or 4'b1100 by addr[1], with data replicated to both halves.
  - sb: byteen one-hot by addr[1:0], with data replicated to all lanes.
- Loads extract the addressed lane from m_data_rdata and sign- or zero-extend it.
- Bridge:
  - Address < DM_LIMIT drives m_data_byteen.
  - Address in 0x7F20–0x7F23 (word store only) drives m_int_byteen.
  - The non-selected byteen output is 0.
  - Loads from 0x7F20 return 0.
- Exceptions (ExcCode): Int 0, AdEL 4, AdES 5, Syscall 8, RI 10, Ov 12.
  - AdEL: misaligned load or fetch, or load outside DM/0x7F20 range.
  - AdES: misaligned store, or store outside DM/0x7F20 range, or sh/sb to 0x7F20.
- CP0 registers:
  - SR($12): IM[15:10], EXL[1], IE[0].
  - Cause($13): IP[15:10] read-only, with IP[12]=interrupt and other IP bits 0; ExcCode[6:2].
  - EPC($14).
  - mtc0 writes SR and EPC only.
- Interrupt condition: IE & ~EXL & |(IM & IP).
  - Sampled combinationally each cycle.
  - Takes priority over any exception of the current instruction.
- On interrupt or exception at PC p:
  - The instruction is squashed: no GRF write, byteen=0.
  - EPC<=p, Cause.ExcCode set, EXL<=1, next PC=HANDLER_PC.
  - macroscopic_pc still shows p that cycle.
- While EXL=1, further interrupts are masked. Exceptions inside the handler still overwrite EPC.
- eret: PC<=EPC, EXL<=0, no write-back.
- PC outside [0x3000, 0x6FFC] or misaligned gives AdEL at fetch. The instruction word is treated as a nop, and EPC=the bad PC.

Test Plan:
- Reset then "ori $1,$0,0x1234; sw $1,0($0)" -> $1<=00001234 at w_inst_addr 3000; *00000000<=00001234 with byteen 1111.
- "lui $2,0x8000; addi $3,$2,-1" -> Ov: no write to $3, EPC=3004, ExcCode=12, next fetch 4180.
- Enable IE with IM[12]=1, then raise interrupt when macroscopic_pc=3018 -> instruction at 3018 not committed, EPC=3018, ExcCode=0, PC=4180. Handler "sw $0,0x7f20($0)" -> m_int_byteen=1111, m_int_addr=7F20, m_data_byteen=0. eret -> PC=3018, re-executes.
- Interrupt held while EXL=1 -> no nested entry; taken again after eret only if still asserted.
- "sb $t,3($0)" with $t=0xAB, then lbu/lb -> byteen 1000; lbu gives 000000AB, lb gives FFFFFFAB.
- lw at address 0x0002 -> AdEL, ExcCode=4; "sw" at 0x8000 -> AdES, ExcCode=5; undefined opcode -> RI, ExcCode=10; syscall -> ExcCode=8.

Source files
------------

// File: rtl/mips_cpu.sv
// mips_cpu: single-cycle MIPS-32 subset core with CP0,
// precise exceptions and a store bridge to the interrupt generator.
module mips_cpu #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] DM_LIMIT   = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        interrupt,
  output logic [31:0] macroscopic_pc,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_int_addr,
  output logic [3:0]  m_int_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);

  typedef enum logic [4:0] {
    K_ADD, K_ADDU, K_SUB, K_SUBU, K_AND, K_OR,
    K_SLT, K_SLTU, K_SLL,
    K_ADDI, K_ADDIU, K_ANDI, K_ORI, K_LUI,
    K_LW, K_LH, K_LHU, K_LB, K_LBU,
    K_SW, K_SH, K_SB,
    K_BEQ, K_BNE, K_J, K_JAL, K_JR,
    K_MFC0, K_MTC0, K_ERET, K_SYSCALL, K_RI
  } kind_e;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [31:0] SR_MASK = 32'h0000_FC03;

  logic [31:0] pc, sr, epc;
  logic [4:0]  exc_q;
  logic [31:0] grf [32];

  logic        pc_bad;
  logic [31:0] inst, pc4;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_s, imm_z;
  kind_e       kind;

  assign pc_bad = (|pc[1:0]) || (pc < 32'h3000) || (pc > 32'h6FFC);
  // A faulting fetch executes as sll $0 so nothing else can trap.
  assign inst  = pc_bad ? 32'h0 : i_inst_rdata;
  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign shamt = inst[10:6];
  assign funct = inst[5:0];
  assign imm   = inst[15:0];
  assign imm_s = {{16{imm[15]}}, imm};
  assign imm_z = {16'h0, imm};
  assign pc4   = pc + 32'd4;

  always_comb begin
    kind = K_RI;
    case (op)
      6'h00: begin
        case (funct)
          6'h20: kind = K_ADD;
          6'h21: kind = K_ADDU;
          6'h22: kind = K_SUB;
          6'h23: kind = K_SUBU;
          6'h24: kind = K_AND;
          6'h25: kind = K_OR;
          6'h2a: kind = K_SLT;
          6'h2b: kind = K_SLTU;
          6'h00: kind = K_SLL;
          6'h08: kind = K_JR;
          6'h0c: kind = K_SYSCALL;
          default: kind = K_RI;
        endcase
      end
      6'h08: kind = K_ADDI;
      6'h09: kind = K_ADDIU;
      6'h0c: kind = K_ANDI;
      6'h0d: kind = K_ORI;
      6'h0f: kind = K_LUI;
      6'h23: kind = K_LW;
      6'h21: kind = K_LH;
      6'h25: kind = K_LHU;
      6'h20: kind = K_LB;
      6'h24: kind = K_LBU;
      6'h2b: kind = K_SW;
      6'h29: kind = K_SH;
      6'h28: kind = K_SB;
      6'h04: kind = K_BEQ;
      6'h05: kind = K_BNE;
      6'h02: kind = K_J;
      6'h03: kind = K_JAL;
      6'h10: begin
        if (rs == 5'h00)
          kind = K_MFC0;
        else if (rs == 5'h04)
          kind = K_MTC0;
        else if (rs == 5'h10 && funct == 6'h18)
          kind = K_ERET;
      end
      default: kind = K_RI;
    endcase
  end

  logic [31:0] rs_val, rt_val;
  assign rs_val = (rs == 5'd0) ? 32'h0 : grf[rs];
  assign rt_val = (rt == 5'd0) ? 32'h0 : grf[rt];

  logic [32:0] add33, sub33, addi33;
  logic [31:0] addr;
  assign add33  = {rs_val[31], rs_val} + {rt_val[31], rt_val};
  assign sub33  = {rs_val[31], rs_val} - {rt_val[31], rt_val};
  assign addi33 = {rs_val[31], rs_val} + {imm_s[31], imm_s};
  assign addr   = addi33[31:0];

  logic is_load, is_store, misalign, in_dm, in_int, mapped, ov;
  assign is_load  = kind inside {K_LW, K_LH, K_LHU, K_LB, K_LBU};
  assign is_store = kind inside {K_SW, K_SH, K_SB};
  assign misalign = (kind inside {K_LW, K_SW}) ? (|addr[1:0]) :
                    (kind inside {K_LH, K_LHU, K_SH}) ? addr[0] : 1'b0;
  assign in_dm  = addr < DM_LIMIT;
  assign in_int = addr[31:2] == 30'h1FC8;
  assign mapped = in_dm || in_int;
  assign ov = (kind == K_ADD  && (add33[32]  ^ add33[31]))  ||
              (kind == K_SUB  && (sub33[32]  ^ sub33[31]))  ||
              (kind == K_ADDI && (addi33[32] ^ addi33[31]));

  logic [5:0]  ip;
  logic [31:0] cause, cp0_rd;
  logic        int_req, exc, take;
  logic [4:0]  code, take_code;
  assign ip      = {3'b000, interrupt, 2'b00};
  assign cause   = {16'h0, ip, 3'b000, exc_q, 2'b00};
  assign int_req = sr[0] & ~sr[1] & (|(sr[15:10] & ip));

  always_comb begin
    exc  = 1'b1;
    code = EXC_ADEL;
    if (pc_bad)
      code = EXC_ADEL;
    else if (kind == K_RI)
      code = EXC_RI;
    else if (kind == K_SYSCALL)
      code = EXC_SYS;
    else if (ov)
      code = EXC_OV;
    else if (is_load && (misalign || !mapped))
      code = EXC_ADEL;
    else if (is_store && (misalign || !mapped ||
             (in_int && kind != K_SW)))
      code = EXC_ADES;
    else
      exc = 1'b0;
  end

  assign take      = int_req | exc;
  assign take_code = int_req ? EXC_INT : code;

  always_comb begin
    case (rd)
      5'd12:   cp0_rd = sr;
      5'd13:   cp0_rd = cause;
      5'd14:   cp0_rd = epc;
      default: cp0_rd = 32'h0;
    endcase
  end

  logic [31:0] ld_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  assign ld_word = in_int ? 32'h0 : m_data_rdata;
  assign ld_byte = ld_word[{addr[1:0], 3'b000} +: 8];
  assign ld_half = addr[1] ? ld_word[31:16] : ld_word[15:0];

  logic        wb_en;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;

  always_comb begin
    wb_en   = 1'b1;
    wb_dst  = rd;
    wb_data = 32'h0;
    unique case (kind)
      K_ADD, K_ADDU: wb_data = add33[31:0];
      K_SUB, K_SUBU: wb_data = sub33[31:0];
      K_AND:  wb_data = rs_val & rt_val;
      K_OR:   wb_data = rs_val | rt_val;
      K_SLT:  wb_data = {31'h0, $signed(rs_val) < $signed(rt_val)};
      K_SLTU: wb_data = {31'h0, rs_val < rt_val};
      K_SLL:  wb_data = rt_val << shamt;
      K_ADDI, K_ADDIU: begin
        wb_dst  = rt;
        wb_data = addr;
      end
      K_ANDI: begin
        wb_dst  = rt;
        wb_data = rs_val & imm_z;
      end
      K_ORI: begin
        wb_dst  = rt;
        wb_data = rs_val | imm_z;
      end
      K_LUI: begin
        wb_dst  = rt;
        wb_data = {imm, 16'h0};
      end
      K_LW: begin
        wb_dst  = rt;
        wb_data = ld_word;
      end
      K_LH: begin
        wb_dst  = rt;
        wb_data = {{16{ld_half[15]}}, ld_half};
      end
      K_LHU: begin
        wb_dst  = rt;
        wb_data = {16'h0, ld_half};
      end
      K_LB: begin
        wb_dst  = rt;
        wb_data = {{24{ld_byte[7]}}, ld_byte};
      end
      K_LBU: begin
        wb_dst  = rt;
        wb_data = {24'h0, ld_byte};
      end
      K_MFC0: begin
        wb_dst  = rt;
        wb_data = cp0_rd;
      end
      K_JAL: begin
        wb_dst  = 5'd31;
        wb_data = pc4;
      end
      default: wb_en = 1'b0;
    endcase
  end

  logic [3:0]  st_be;
  always_comb begin
    st_be        = 4'b0000;
    m_data_wdata = rt_val;
    case (kind)
      K_SW: st_be = 4'b1111;
      K_SH: begin
        st_be        = addr[1] ? 4'b1100 : 4'b0011;
        m_data_wdata = {2{rt_val[15:0]}};
      end
      K_SB: begin
        st_be        = 4'b0001 << addr[1:0];
        m_data_wdata = {4{rt_val[7:0]}};
      end
      default: ;
    endcase
  end

  logic [31:0] npc;
  always_comb begin
    npc = pc4;
    case (kind)
      K_BEQ: if (rs_val == rt_val) npc = pc4 + (imm_s << 2);
      K_BNE: if (rs_val != rt_val) npc = pc4 + (imm_s << 2);
      K_J, K_JAL: npc = {pc4[31:28], inst[25:0], 2'b00};
      K_JR:   npc = rs_val;
      K_ERET: npc = epc;
      default: ;
    endcase
    if (take)
      npc = HANDLER_PC;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc    <= PC_RESET;
      sr    <= 32'h0;
      epc   <= 32'h0;
      exc_q <= 5'd0;
      for (int i = 0; i < 32; i++)
        grf[i] <= 32'h0;
    end else begin
      pc <= npc;
      if (take) begin
        epc   <= pc;
        exc_q <= take_code;
        sr[1] <= 1'b1;
      end else begin
        if (kind == K_MTC0 && rd == 5'd12)
          sr <= rt_val & SR_MASK;
        if (kind == K_MTC0 && rd == 5'd14)
          epc <= rt_val;
        if (kind == K_ERET)
          sr[1] <= 1'b0;
        if (wb_en && wb_dst != 5'd0)
          grf[wb_dst] <= wb_data;
      end
    end
  end

  logic st_go;
  assign st_go = ~reset & is_store & ~take;

  assign macroscopic_pc = pc;
  assign i_inst_addr    = pc;
  assign m_inst_addr    = pc;
  assign w_inst_addr    = pc;
  assign m_data_addr    = addr;
  assign m_int_addr     = addr;
  assign m_data_byteen  = (st_go & in_dm)  ? st_be : 4'b0000;
  assign m_int_byteen   = (st_go & in_int) ? st_be : 4'b0000;
  assign w_grf_we       = ~reset & ~take & wb_en;
  assign w_grf_addr     = wb_dst;
  assign w_grf_wdata    = wb_data;

endmodule

// File: tb/tb_mips_cpu.sv
// tb_mips_cpu: program-driven bench for mips_cpu with a write-back
// and store scoreboard plus per-scenario inline checks.
module tb_mips_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        interrupt = 1'b0;
  logic [31:0] macroscopic_pc, i_inst_addr, i_inst_rdata;
  logic [31:0] m_data_addr, m_data_rdata, m_data_wdata;
  logic [3:0]  m_data_byteen, m_int_byteen;
  logic [31:0] m_int_addr, m_inst_addr;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata, w_inst_addr;

  always #5 clk = ~clk;

  mips_cpu dut (
    .clk(clk), .reset(reset), .interrupt(interrupt),
    .macroscopic_pc(macroscopic_pc),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata),
    .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen),
    .m_inst_addr(m_inst_addr),
    .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr),
    .w_grf_wdata(w_grf_wdata), .w_inst_addr(w_inst_addr)
  );

  logic [31:0] imem [4096];
  logic [31:0] dmem [3072];
  logic [31:0] ioff;

  assign ioff = i_inst_addr - 32'h3000;
  always_comb begin
    i_inst_rdata = 32'h0;
    if (i_inst_addr >= 32'h3000 && i_inst_addr < 32'h7000)
      i_inst_rdata = imem[ioff[13:2]];
  end
  assign m_data_rdata = (m_data_addr < 32'h3000) ?
                        dmem[m_data_addr[13:2]] : 32'h0;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (m_data_byteen[b])
        dmem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
  end

  int n_cmp = 0;
  int n_bad = 0;
  logic [68:0] wq [$];
  logic [71:0] sq [$];

  // Scoreboard: every committed non-$0 write and every store is popped here.
  always @(negedge clk) begin
    logic [68:0] we;
    logic [71:0] se;
    if (!reset) begin
      if (w_grf_we && w_grf_addr != 5'd0) begin
        n_cmp++;
        if (wq.size() == 0) begin
          n_bad++;
          $display("FAIL grf_write unexpected: got pc=%h r%0d=%h, required none",
                   w_inst_addr, w_grf_addr, w_grf_wdata);
        end else begin
          we = wq.pop_front();
          if ({w_inst_addr, w_grf_addr, w_grf_wdata} !== we) begin
            n_bad++;
            $display("FAIL grf_write: got pc=%h r%0d=%h, required pc=%h r%0d=%h",
                     w_inst_addr, w_grf_addr, w_grf_wdata,
                     we[68:37], we[36:32], we[31:0]);
          end
        end
      end
      if (m_data_byteen != 4'b0 || m_int_byteen != 4'b0) begin
        n_cmp++;
        if (sq.size() == 0) begin
          n_bad++;
          $display("FAIL store unexpected: got addr=%h data=%h be=%b/%b, required none",
                   m_data_addr, m_data_wdata, m_data_byteen, m_int_byteen);
        end else begin
          se = sq.pop_front();
          if ({m_data_addr, m_data_wdata, m_data_byteen, m_int_byteen} !== se) begin
            n_bad++;
            $display("FAIL store: got %h %h %b %b, required %h %h %b %b",
                     m_data_addr, m_data_wdata, m_data_byteen, m_int_byteen,
                     se[71:40], se[39:8], se[7:4], se[3:0]);
          end
        end
      end
    end
  end

  function automatic logic [31:0] r_t(input logic [5:0] fn,
      input logic [4:0] s, input logic [4:0] t,
      input logic [4:0] d, input logic [4:0] sh);
    return {6'h00, s, t, d, sh, fn};
  endfunction
  function automatic logic [31:0] i_t(input logic [5:0] o,
      input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
    return {o, s, t, im};
  endfunction
  function automatic logic [31:0] mfc0(input logic [4:0] t, input logic [4:0] d);
    return {6'h10, 5'h00, t, d, 11'h0};
  endfunction
  function automatic logic [31:0] mtc0(input logic [4:0] t, input logic [4:0] d);
    return {6'h10, 5'h04, t, d, 11'h0};
  endfunction

  localparam logic [31:0] HALT    = {6'h04, 10'h0, 16'hFFFF};
  localparam logic [31:0] ERET    = 32'h4200_0018;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    logic [31:0] o;
    o = a - 32'h3000;
    imem[o[13:2]] = w;
  endtask

  task automatic begin_load();
    reset = 1'b1;
    interrupt = 1'b0;
    @(posedge clk);
    foreach (imem[i]) imem[i] = 32'h0;
  endtask

  task automatic go();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input string name);
    n_cmp++;
    if (wq.size() != 0 || sq.size() != 0) begin
      n_bad++;
      $display("FAIL %s drain: got %0d writes/%0d stores pending, required 0/0",
               name, wq.size(), sq.size());
    end
    wq.delete();
    sq.delete();
  endtask

  task automatic test_reset();
    begin_load();
    put(32'h3000, i_t(6'h0d, 0, 1, 16'h1234));
    put(32'h3004, i_t(6'h2b, 0, 1, 16'h0000));
    put(32'h3008, HALT);
    @(negedge clk);
    n_cmp++;
    if ({macroscopic_pc, w_grf_we, m_data_byteen, m_int_byteen} !==
        {32'h3000, 1'b0, 4'b0, 4'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got pc=%h we=%b be=%b/%b, required 3000 0 0000/0000",
               macroscopic_pc, w_grf_we, m_data_byteen, m_int_byteen);
    end
    wq.push_back({32'h3000, 5'd1, 32'h0000_1234});
    sq.push_back({32'h0, 32'h0000_1234, 4'b1111, 4'b0000});
    go();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_data_byteen !== 4'b1111) begin
      n_bad++;
      $display("FAIL sw_byteen: got %b, required 1111", m_data_byteen);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dmem[0] !== 32'h0000_1234) begin
      n_bad++;
      $display("FAIL dmem0: got %h, required 00001234", dmem[0]);
    end
    drain("reset");
  endtask

  task automatic test_alu_branch();
    begin_load();
    put(32'h3000, i_t(6'h0d, 0, 1, 16'h0005));
    put(32'h3004, i_t(6'h09, 0, 2, 16'hFFFD));
    put(32'h3008, r_t(6'h2a, 2, 1, 3, 0));
    put(32'h300c, r_t(6'h2b, 2, 1, 4, 0));
    put(32'h3010, r_t(6'h00, 0, 1, 5, 4));
    put(32'h3014, r_t(6'h23, 1, 2, 6, 0));
    put(32'h3018, i_t(6'h05, 1, 2, 16'h0001));
    put(32'h301c, i_t(6'h0d, 0, 7, 16'hDEAD));
    put(32'h3020, {6'h03, 26'h0000C0C});
    put(32'h3024, i_t(6'h0d, 0, 8, 16'h0077));
    put(32'h3028, HALT);
    put(32'h3030, r_t(6'h24, 1, 2, 9, 0));
    put(32'h3034, r_t(6'h08, 31, 0, 0, 0));
    wq.push_back({32'h3000, 5'd1,  32'h0000_0005});
    wq.push_back({32'h3004, 5'd2,  32'hFFFF_FFFD});
    wq.push_back({32'h3008, 5'd3,  32'h0000_0001});
    wq.push_back({32'h300c, 5'd4,  32'h0000_0000});
    wq.push_back({32'h3010, 5'd5,  32'h0000_0050});
    wq.push_back({32'h3014, 5'd6,  32'h0000_0008});
    wq.push_back({32'h3020, 5'd31, 32'h0000_3024});
    wq.push_back({32'h3030, 5'd9,  32'h0000_0005});
    wq.push_back({32'h3024, 5'd8,  32'h0000_0077});
    go();
    repeat (16) @(negedge clk);
    n_cmp++;
    if (macroscopic_pc !== 32'h3028) begin
      n_bad++;
      $display("FAIL alu_halt_pc: got %h, required 00003028", macroscopic_pc);
    end
    drain("alu_branch");
  endtask

  task automatic test_overflow();
    begin_load();
    put(32'h3000, i_t(6'h0f, 0, 2, 16'h8000));
    put(32'h3004, i_t(6'h08, 2, 3, 16'hFFFF));
    put(32'h3008, HALT);
    put(32'h4180, mfc0(26, 14));
    put(32'h4184, mfc0(27, 13));
    put(32'h4188, HALT);
    wq.push_back({32'h3000, 5'd2,  32'h8000_0000});
    wq.push_back({32'h4180, 5'd26, 32'h0000_3004});
    wq.push_back({32'h4184, 5'd27, 32'h0000_0030});
    go();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({macroscopic_pc, w_grf_we} !== {32'h3004, 1'b0}) begin
      n_bad++;
      $display("FAIL ov_squash: got pc=%h we=%b, required 00003004 0",
               macroscopic_pc, w_grf_we);
    end
    @(negedge clk);
    n_cmp++;
    if (macroscopic_pc !== 32'h4180) begin
      n_bad++;
      $display("FAIL ov_vector: got %h, required 00004180", macroscopic_pc);
    end
    repeat (4) @(negedge clk);
    drain("overflow");
  endtask

  task automatic test_interrupt();
    begin_load();
    put(32'h3000, i_t(6'h0d, 0, 1, 16'h1001));
    put(32'h3004, mtc0(1, 12));
    put(32'h3008, i_t(6'h0d, 0, 2, 16'h0001));
    put(32'h300c, i_t(6'h0d, 0, 2, 16'h0002));
    put(32'h3010, i_t(6'h0d, 0, 2, 16'h0003));
    put(32'h3014, i_t(6'h0d, 0, 2, 16'h0004));
    put(32'h3018, i_t(6'h0d, 0, 3, 16'h0055));
    put(32'h301c, HALT);
    put(32'h4180, mfc0(26, 14));
    put(32'h4184, mfc0(27, 13));
    put(32'h4188, i_t(6'h2b, 0, 0, 16'h7F20));
    put(32'h418c, ERET);
    wq.push_back({32'h3000, 5'd1,  32'h0000_1001});
    wq.push_back({32'h3008, 5'd2,  32'h0000_0001});
    wq.push_back({32'h300c, 5'd2,  32'h0000_0002});
    wq.push_back({32'h3010, 5'd2,  32'h0000_0003});
    wq.push_back({32'h3014, 5'd2,  32'h0000_0004});
    wq.push_back({32'h4180, 5'd26, 32'h0000_3018});
    wq.push_back({32'h4184, 5'd27, 32'h0000_1000});
    wq.push_back({32'h3018, 5'd3,  32'h0000_0055});
    sq.push_back({32'h7F20, 32'h0, 4'b0000, 4'b1111});
    go();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 interrupt = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({macroscopic_pc, w_grf_we} !== {32'h3018, 1'b0}) begin
      n_bad++;
      $display("FAIL int_squash: got pc=%h we=%b, required 00003018 0",
               macroscopic_pc, w_grf_we);
    end
    @(negedge clk);
    n_cmp++;
    if (macroscopic_pc !== 32'h4180) begin
      n_bad++;
      $display("FAIL int_vector: got %h, required 00004180", macroscopic_pc);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({m_int_addr, m_int_byteen, m_data_byteen} !==
        {32'h7F20, 4'b1111, 4'b0000}) begin
      n_bad++;
      $display("FAIL int_ack: got addr=%h ibe=%b dbe=%b, required 00007f20 1111 0000",
               m_int_addr, m_int_byteen, m_data_byteen);
    end
    @(posedge clk);
    #1 interrupt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({macroscopic_pc, w_grf_we, w_grf_addr} !== {32'h3018, 1'b1, 5'd3}) begin
      n_bad++;
      $display("FAIL eret_replay: got pc=%h we=%b r%0d, required 00003018 1 r3",
               macroscopic_pc, w_grf_we, w_grf_addr);
    end
    repeat (3) @(negedge clk);
    drain("interrupt");
  endtask

  task automatic test_nested();
    begin_load();
    put(32'h3000, i_t(6'h0d, 0, 1, 16'h1001));
    put(32'h3004, mtc0(1, 12));
    put(32'h3008, HALT);
    put(32'h4180, mfc0(26, 14));
    put(32'h4184, mfc0(27, 13));
    put(32'h4188, ERET);
    wq.push_back({32'h3000, 5'd1,  32'h0000_1001});
    wq.push_back({32'h4180, 5'd26, 32'h0000_3008});
    wq.push_back({32'h4184, 5'd27, 32'h0000_1000});
    wq.push_back({32'h4180, 5'd26, 32'h0000_3008});
    wq.push_back({32'h4184, 5'd27, 32'h0000_1000});
    go();
    interrupt = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (macroscopic_pc !== 32'h4184) begin
      n_bad++;
      $display("FAIL exl_mask: got %h, required 00004184", macroscopic_pc);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (macroscopic_pc !== 32'h4180) begin
      n_bad++;
      $display("FAIL reenter_after_eret: got %h, required 00004180", macroscopic_pc);
    end
    @(negedge clk);
    @(posedge clk);
    #1 interrupt = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (macroscopic_pc !== 32'h3008) begin
      n_bad++;
      $display("FAIL no_reenter: got %h, required 00003008", macroscopic_pc);
    end
    drain("nested");
  endtask

  task automatic test_byte_half();
    begin_load();
    put(32'h3000, i_t(6'h0d, 0, 1, 16'h00AB));
    put(32'h3004, i_t(6'h28, 0, 1, 16'h0003));
    put(32'h3008, i_t(6'h24, 0, 2, 16'h0003));
    put(32'h300c, i_t(6'h20, 0, 3, 16'h0003));
    put(32'h3010, i_t(6'h29, 0, 1, 16'h0006));
    put(32'h3014, i_t(6'h25, 0, 4, 16'h0006));
    put(32'h3018, HALT);
    wq.push_back({32'h3000, 5'd1, 32'h0000_00AB});
    wq.push_back({32'h3008, 5'd2, 32'h0000_00AB});
    wq.push_back({32'h300c, 5'd3, 32'hFFFF_FFAB});
    wq.push_back({32'h3014, 5'd4, 32'h0000_00AB});
    sq.push_back({32'h3, 32'hABAB_ABAB, 4'b1000, 4'b0000});
    sq.push_back({32'h6, 32'h00AB_00AB, 4'b1100, 4'b0000});
    go();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (m_data_byteen !== 4'b1000) begin
      n_bad++;
      $display("FAIL sb_byteen: got %b, required 1000", m_data_byteen);
    end
    repeat (7) @(negedge clk);
    drain("byte_half");
  endtask

  task automatic test_exceptions();
    logic [31:0] ret [5];
    logic [31:0] cz [5];
    logic [31:0] fp [5];
    begin_load();
    put(32'h3000, i_t(6'h23, 0, 1, 16'h0002));
    put(32'h3004, i_t(6'h0d, 0, 5, 16'h8000));
    put(32'h3008, i_t(6'h2b, 5, 0, 16'h0000));
    put(32'h300c, 32'hFC00_0000);
    put(32'h3010, SYSCALL);
    put(32'h3014, i_t(6'h28, 0, 0, 16'h7F20));
    put(32'h3018, HALT);
    put(32'h4180, mfc0(26, 14));
    put(32'h4184, mfc0(27, 13));
    put(32'h4188, i_t(6'h09, 26, 26, 16'h0004));
    put(32'h418c, mtc0(26, 14));
    put(32'h4190, ERET);
    fp = '{32'h3000, 32'h3008, 32'h300c, 32'h3010, 32'h3014};
    cz = '{32'h10, 32'h14, 32'h28, 32'h20, 32'h14};
    for (int k = 0; k < 5; k++) begin
      ret[k] = fp[k] + 32'd4;
      if (k == 1)
        wq.push_back({32'h3004, 5'd5, 32'h0000_8000});
      wq.push_back({32'h4180, 5'd26, fp[k]});
      wq.push_back({32'h4184, 5'd27, cz[k]});
      wq.push_back({32'h4188, 5'd26, ret[k]});
    end
    go();
    @(negedge clk);
    n_cmp++;
    if ({macroscopic_pc, w_grf_we} !== {32'h3000, 1'b0}) begin
      n_bad++;
      $display("FAIL adel_squash: got pc=%h we=%b, required 00003000 0",
               macroscopic_pc, w_grf_we);
    end
    @(negedge clk);
    n_cmp++;
    if (macroscopic_pc !== 32'h4180) begin
      n_bad++;
      $display("FAIL adel_vector: got %h, required 00004180", macroscopic_pc);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (macroscopic_pc !== 32'h3018) begin
      n_bad++;
      $display("FAIL exc_end_pc: got %h, required 00003018", macroscopic_pc);
    end
    drain("exceptions");
  endtask

  initial begin
    test_reset();
    test_alu_branch();
    test_overflow();
    test_interrupt();
    test_nested();
    test_byte_half();
    test_exceptions();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
